// File: rtl/alu_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_if
//
// Bundles the three buses around the ALU command sequencer:
//   command  : cmd_valid / cmd_ready plus cmd_op, cmd_dst, cmd_srca, cmd_srcb,
//              cmd_imm_en, cmd_imm            (producer -> sequencer)
//   ALU      : alu_c, alu_a, alu_b            (sequencer -> ALU)
//              alu_s, alu_cout                (ALU -> sequencer)
//   response : rsp_valid / rsp_ready plus rsp_data, rsp_cout, rsp_err
//              (sequencer -> consumer)
//
// Modports:
//   slave  : the sequencer itself
//   master : the surrounding system (command producer, ALU, response consumer)
// ---------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [1:0]       cmd_dst;
  logic [1:0]       cmd_srca;
  logic [1:0]       cmd_srcb;
  logic             cmd_imm_en;
  logic [WIDTH-1:0] cmd_imm;

  logic [3:0]       alu_c;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_s;
  logic             alu_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_c, alu_a, alu_b,
    input  alu_s, alu_cout,
    output rsp_valid, rsp_data, rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_c, alu_a, alu_b,
    output alu_s, alu_cout,
    input  rsp_valid, rsp_data, rsp_cout, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Sequencer placed directly upstream of the 8-bit ALU. Takes one register-level
// command at a time, reads its operands from a 4 x 8 register file, presents
// them to the ALU, captures the result and carry, writes the result back and
// returns a response.
//
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   bus        : alu_cmd_sequencer_if.slave (command, ALU and response buses)
//   dbg_state  : current FSM state (IDLE=0, ISSUE=1, CAPTURE=2, RESP=3)
//   dbg_rf     : register file contents, rf[i] at dbg_rf[i*WIDTH +: WIDTH]
//
// Handshakes (both buses): a transfer happens at a rising edge where valid and
// ready are both 1. The sender holds valid and its payload stable until that
// edge; ready may be asserted independently of valid.
//
// Build option:
//   ALU_SEQ_IMM_EN defined   : cmd_imm_en selects cmd_imm as ALU operand B.
//   ALU_SEQ_IMM_EN undefined : operand B is always rf[srcb]; cmd_imm only
//                              feeds LOAD.
//
// Opcodes: 0000 LOAD immediate (bypasses the ALU), 0001-0100 arithmetic
// (carry reported), 0110/0111 min/max, 1000-1101 shifts/rotates,
// 0101/1110/1111 illegal (no writeback, rsp_err=1).
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int NREGS = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_sequencer_if.slave     bus,
  output logic [1:0]             dbg_state,
  output logic [NREGS*WIDTH-1:0] dbg_rf
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [3:0] OP_LOAD = 4'b0000;

  logic [1:0]       state;
  logic [WIDTH-1:0] rf [NREGS];

  // Command fields latched at accept; operands are read at accept too, which
  // is the last point before ISSUE and sees the pre-command register values.
  logic [3:0]       op_q;
  logic [1:0]       dst_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] cap_s;
  logic             cap_cout;

  logic [3:0]       alu_c_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;

  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_cout_q;
  logic             rsp_err_q;

  logic [WIDTH-1:0] opnd_b;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b0101) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

  // Only add/inc/sub/dec produce a meaningful carry; for every other op the
  // ALU's cout is whatever it was left at and must not leak out.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011) || (op == 4'b0100);
  endfunction

`ifdef ALU_SEQ_IMM_EN
  always_comb begin
    opnd_b = bus.cmd_imm_en ? bus.cmd_imm : rf[bus.cmd_srcb];
  end
`else
  always_comb begin
    opnd_b = rf[bus.cmd_srcb];
  end

  // cmd_imm_en has no effect in this build.
  logic unused_imm_en;
  assign unused_imm_en = bus.cmd_imm_en;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      cap_s      <= '0;
      cap_cout   <= 1'b0;
      alu_c_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            dst_q <= bus.cmd_dst;
            imm_q <= bus.cmd_imm;
            state <= ISSUE;
            // LOAD and illegal ops never drive the ALU.
            if (bus.cmd_op != OP_LOAD && !is_illegal(bus.cmd_op)) begin
              alu_c_q <= bus.cmd_op;
              alu_a_q <= rf[bus.cmd_srca];
              alu_b_q <= opnd_b;
            end else begin
              alu_c_q <= '0;
              alu_a_q <= '0;
              alu_b_q <= '0;
            end
          end
        end

        ISSUE: begin
          cap_s    <= bus.alu_s;
          cap_cout <= bus.alu_cout;
          state    <= CAPTURE;
        end

        CAPTURE: begin
          if (op_q == OP_LOAD) begin
            rf[dst_q]  <= imm_q;
            rsp_data_q <= imm_q;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
          end else if (is_illegal(op_q)) begin
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b1;
          end else begin
            rf[dst_q]  <= cap_s;
            rsp_data_q <= cap_s;
            rsp_cout_q <= is_arith(op_q) ? cap_cout : 1'b0;
            rsp_err_q  <= 1'b0;
          end
          state <= RESP;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            alu_c_q <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_c     = alu_c_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;

  assign dbg_state = state;

  always_comb begin
    dbg_rf = '0;
    for (int i = 0; i < NREGS; i++) begin
      dbg_rf[i*WIDTH +: WIDTH] = rf[i];
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Bench for alu_cmd_sequencer. A behavioural 8-bit ALU answers the sequencer's
// alu_* outputs. A table of directed commands with hand-derived responses is
// run first, then hand-written backpressure and mid-operation reset sequences,
// then random commands whose responses come from a small reference model.
// Responses are checked by a scoreboard queue popped on each rsp handshake.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       imm_en;
    logic [7:0] imm;
    logic [7:0] exp_data;
    logic       exp_cout;
    logic       exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_rf;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_rf    (dbg_rf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU ----------------
  // Non-arithmetic ops leave cout at 1 so a leaked carry is visible.
  function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] r;
    case (c)
      4'b0001: r = {1'b0, a} + {1'b0, b};
      4'b0010: r = {1'b0, a} + 9'd1;
      4'b0011: r = {1'b0, a} + {1'b0, ~b} + 9'd1;
      4'b0100: r = {1'b0, a} + 9'h0FF;
      4'b0110: r = {1'b1, ($signed(a) < $signed(b)) ? a : b};
      4'b0111: r = {1'b1, ($signed(a) > $signed(b)) ? a : b};
      4'b1000: r = {1'b1, a[0], a[7:1]};
      4'b1001: r = {1'b1, a[6:0], a[7]};
      4'b1010: r = {1'b1, 1'b0, a[7:1]};
      4'b1011: r = {1'b1, a[6:0], 1'b0};
      4'b1100: r = {1'b1, a[7], a[7:1]};
      4'b1101: r = {1'b1, a[3:0], a[7:4]};
      default: r = 9'h100;
    endcase
    return r;
  endfunction

  always_comb begin
    {bus.alu_cout, bus.alu_s} = alu_f(bus.alu_c, bus.alu_a, bus.alu_b);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  logic [7:0] exp_rf [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_rf();
    return {exp_rf[3], exp_rf[2], exp_rf[1], exp_rf[0]};
  endfunction

  function automatic logic legal_alu(input logic [3:0] op);
    return !(op == 4'b0000 || op == 4'b0101 || op == 4'b1110 || op == 4'b1111);
  endfunction

  function automatic logic [7:0] b_sel(input logic [1:0] srcb, input logic ie,
                                       input logic [7:0] imm);
`ifdef ALU_SEQ_IMM_EN
    return ie ? imm : exp_rf[srcb];
`else
    return (ie & 1'b0) ? imm : exp_rf[srcb];
`endif
  endfunction

  // Reference response for a command against the current model register file.
  function automatic vec_t make_exp(input logic [3:0] op, input logic [1:0] dst,
                                    input logic [1:0] srca, input logic [1:0] srcb,
                                    input logic ie, input logic [7:0] imm);
    vec_t v;
    logic [8:0] r;
    v.op = op; v.dst = dst; v.srca = srca; v.srcb = srcb; v.imm_en = ie; v.imm = imm;
    if (op == 4'b0000) begin
      v.exp_data = imm; v.exp_cout = 1'b0; v.exp_err = 1'b0;
    end else if (!legal_alu(op)) begin
      v.exp_data = 8'h00; v.exp_cout = 1'b0; v.exp_err = 1'b1;
    end else begin
      r = alu_f(op, exp_rf[srca], b_sel(srcb, ie, imm));
      v.exp_data = r[7:0];
      v.exp_cout = (op >= 4'd1 && op <= 4'd4) ? r[8] : 1'b0;
      v.exp_err  = 1'b0;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] dst,
                              input logic [1:0] srca, input logic [1:0] srcb,
                              input logic ie, input logic [7:0] imm,
                              input logic [7:0] d, input logic c, input logic e);
    vec_t v;
    v.op = op; v.dst = dst; v.srca = srca; v.srcb = srcb; v.imm_en = ie; v.imm = imm;
    v.exp_data = d; v.exp_cout = c; v.exp_err = e;
    return v;
  endfunction

  // Scoreboard: every response handshake pops one expected record.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        check("rsp", {22'd0, bus.rsp_err, bus.rsp_cout, bus.rsp_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_fields(input vec_t v);
    bus.cmd_op = v.op; bus.cmd_dst = v.dst; bus.cmd_srca = v.srca;
    bus.cmd_srcb = v.srcb; bus.cmd_imm_en = v.imm_en; bus.cmd_imm = v.imm;
  endtask

  // Presents a command and returns #1 after the accepting edge (in ISSUE).
  task automatic send_cmd(input vec_t v);
    int n;
    drive_fields(v);
    bus.cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Counts negedges from ISSUE until rsp_valid is seen; 3 means T+3.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic [3:0] e_c;
    logic [7:0] e_a, e_b;
    if (legal_alu(v.op)) begin
      e_c = v.op; e_a = exp_rf[v.srca]; e_b = b_sel(v.srcb, v.imm_en, v.imm);
    end else begin
      e_c = 4'd0; e_a = 8'd0; e_b = 8'd0;
    end
    exp_q.push_back({v.exp_err, v.exp_cout, v.exp_data});
    send_cmd(v);
    check({tag, "_alu_c"}, {28'd0, bus.alu_c}, {28'd0, e_c});
    check({tag, "_alu_a"}, {24'd0, bus.alu_a}, {24'd0, e_a});
    check({tag, "_alu_b"}, {24'd0, bus.alu_b}, {24'd0, e_b});
    wait_rsp(lat);
    check({tag, "_latency"}, lat, 32'd3);
    @(posedge clk);
    #1;
    if (!v.exp_err) exp_rf[v.dst] = v.exp_data;
    check({tag, "_rf"}, dbg_rf, pack_rf());
    check({tag, "_idle"}, {28'd0, bus.alu_c, dbg_state}, {28'd0, 4'd0, S_IDLE});
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    vec_t v, v2;
    int lat;
    logic saw_valid;

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_srca = '0;
    bus.cmd_srcb = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;

    //            op     dst   a     b     ie    imm    data   c     e
    vecs.push_back(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0));
    vecs.push_back(mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0));
    vecs.push_back(mk(4'h1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0)); // add
    vecs.push_back(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0));
    vecs.push_back(mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h07, 8'h07, 1'b0, 1'b0));
    vecs.push_back(mk(4'h3, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0)); // 5-7
    vecs.push_back(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h07, 8'h07, 1'b0, 1'b0));
    vecs.push_back(mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0));
    vecs.push_back(mk(4'h3, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0)); // 7-5
    vecs.push_back(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0));
    vecs.push_back(mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0));
    vecs.push_back(mk(4'h6, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0)); // min
    vecs.push_back(mk(4'h7, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0)); // max
    vecs.push_back(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0));
    vecs.push_back(mk(4'h8, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0)); // ror
    vecs.push_back(mk(4'h1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h41, 1'b1, 1'b0)); // 81+C0
    vecs.push_back(mk(4'h2, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'hC1, 1'b0, 1'b0)); // inc
    vecs.push_back(mk(4'h0, 2'd3, 2'd0, 2'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0));
    vecs.push_back(mk(4'h2, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0)); // FF+1
    vecs.push_back(mk(4'h4, 2'd0, 2'd3, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0)); // 00-1
    vecs.push_back(mk(4'h5, 2'd0, 2'd1, 2'd2, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b1)); // illegal
    vecs.push_back(mk(4'hE, 2'd1, 2'd2, 2'd3, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(4'hF, 2'd3, 2'd0, 2'd1, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b1));
    vecs.push_back(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0));
`ifdef ALU_SEQ_IMM_EN
    vecs.push_back(mk(4'h1, 2'd2, 2'd0, 2'd1, 1'b1, 8'h22, 8'h32, 1'b0, 1'b0)); // r0+imm
`else
    vecs.push_back(mk(4'h1, 2'd2, 2'd0, 2'd1, 1'b1, 8'h22, 8'hD0, 1'b0, 1'b0)); // r0+r1
`endif
    vecs.push_back(mk(4'h0, 2'd1, 2'd3, 2'd2, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0)); // LOAD, ie=1
    vecs.push_back(mk(4'hB, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'hB4, 1'b0, 1'b0)); // shl
    vecs.push_back(mk(4'h1, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0)); // r0+r0

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_rsp", {28'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_cout, 1'b0}, 32'd0);
    check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
    check("rst_alu", {12'd0, bus.alu_c, bus.alu_a, bus.alu_b}, 32'd0);
    check("rst_rf", dbg_rf, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Directed table
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5+ cycles with a new command waiting
    bus.rsp_ready = 1'b0;
    v = make_exp(4'h1, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00);
    exp_q.push_back({v.exp_err, v.exp_cout, v.exp_data});
    send_cmd(v);
    wait_rsp(lat);
    check("bp_latency", lat, 32'd3);
    @(posedge clk);
    #1;
    v2 = mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0);
    drive_fields(v2);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {20'd0, bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_cout, bus.rsp_data},
            {20'd0, 1'b1, 1'b0, v.exp_err, v.exp_cout, v.exp_data});
      check("bp_state", {30'd0, dbg_state}, {30'd0, S_RESP});
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handshake_idle", {31'd0, bus.cmd_ready}, 32'd1);
    exp_rf[v.dst] = v.exp_data;
    exp_q.push_back({v2.exp_err, v2.exp_cout, v2.exp_data});
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("bp_next_accept", {30'd0, dbg_state}, {30'd0, S_ISSUE});
    wait_rsp(lat);
    check("bp_next_latency", lat, 32'd3);
    @(posedge clk);
    #1;
    exp_rf[v2.dst] = v2.exp_data;
    check("bp_rf", dbg_rf, pack_rf());

    // Reset during ISSUE of an add into r2 that held 0x33
    run_vec(mk(4'h0, 2'd2, 2'd0, 2'd0, 1'b0, 8'h33, 8'h33, 1'b0, 1'b0), "pre_rst");
    send_cmd(mk(4'h1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    check("mid_rst_in_issue", {30'd0, dbg_state}, {30'd0, S_ISSUE});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
    check("mid_rst_rf", dbg_rf, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("mid_rst_alu", {12'd0, bus.alu_c, bus.alu_a, bus.alu_b}, 32'd0);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_rsp", {31'd0, saw_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Random commands against the reference model
    for (int i = 0; i < 40; i++) begin
      v = make_exp(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      run_vec(v, $sformatf("rnd%0d", i));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer that sits directly upstream of the 8-bit ALU. It accepts register-level commands over a valid/ready interface and reads operands from a 4-entry × 8-bit register file. It drives the ALU's opcode and operand inputs, captures the ALU result and carry, and writes the result back. Each completed command returns a response over a second valid/ready interface.

## Interface
Parameters:
- NREGS, 4, register file depth (fixed at 4; 2-bit register indices)
- WIDTH, 8, datapath width (fixed at 8 to match the ALU)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode; 4'b0000 = LOAD immediate
- cmd_dst  in  2  destination register index
- cmd_srca  in  2  operand A register index
- cmd_srcb  in  2  operand B register index
- cmd_imm_en  in  1  B taken from cmd_imm instead of register file
- cmd_imm  in  8  immediate value
- alu_c  out  4  to ALU c
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_s  in  8  from ALU s
- alu_cout  in  1  from ALU cout
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  result written to cmd_dst
- rsp_cout  out  1  carry out (arithmetic ops only)
- rsp_err  out  1  illegal opcode

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid at a rising edge, latch all cmd_* fields and go to ISSUE.
  - ISSUE: drive alu_c=latched op, alu_a=rf[srca], alu_b=(imm_en ? imm : rf[srcb]). At the edge, capture alu_s and alu_cout, go to CAPTURE.
  - CAPTURE: write rf[dst] with the captured result unless err. Set rsp_* from the captured values and go to RESP.
  - RESP: rsp_valid=1; all rsp_* are held stable. On rsp_ready, go to IDLE.
- Legal ALU ops: 0001 add, 0010 inc, 0011 sub, 0100 dec, 0110 min, 0111 max, 1000–1101 shifts/rotates.
- rsp_cout = captured alu_cout for 0001–0100 only; 0 for all other ops. The ALU's cout is stale for non-arithmetic ops.
- LOAD (0000): bypasses the ALU. alu_c is held at 0, rsp_data=cmd_imm, rf[dst]=cmd_imm, rsp_cout=0. LOAD uses cmd_imm regardless of cmd_imm_en or configuration.
- Illegal ops (0101, 1110, 1111): no writeback, rsp_data=0, rsp_cout=0, rsp_err=1. The ALU is not driven; alu_c stays 0.
- srca, srcb and dst may alias. The register file is read in ISSUE and written in CAPTURE, so the read always sees the pre-command value.
- Commands are strictly serialized, so no hazard logic is needed.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE
  - rf[0..3]=0
  - cmd_ready=1 after reset releases
  - alu_c=0, alu_a=0, alu_b=0
  - rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0
- Reset mid-operation, in any state: the in-flight command is dropped with no writeback and no response.
- Accept at edge T. ISSUE in cycle T+1; the combinational ALU settles within the cycle. CAPTURE in T+2. rsp_valid rises in T+3.
- Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
- alu_* outputs are registered. They change only on entry to ISSUE and return to 0 on entry to IDLE.
- cmd_ready is 0 in ISSUE, CAPTURE and RESP. A command presented then must be held by the producer.
- rsp_valid stays high with stable rsp_* until rsp_ready. The handshake cycle returns to IDLE; a new command can be accepted from the following edge.
- All arithmetic is modulo 2^8. Sub uses the ALU's two's-complement path. min/max are signed (ALU semantics).

## Configuration
- ALU_SEQ_IMM_EN defined: cmd_imm_en selects cmd_imm as operand B for ALU ops.
- ALU_SEQ_IMM_EN undefined: cmd_imm_en is ignored and operand B is always rf[srcb]. cmd_imm is used only by LOAD.

## Test plan
- Add: LOAD r0=0x7F, LOAD r1=0x01, then add dst=r2, a=r0, b=r1 -> rsp_data=0x80, rsp_cout=0, rf[2]=0x80. rsp_valid rises 3 cycles after accept.
- Sub: r0=0x05, r1=0x07, sub dst=r3 -> rsp_data=0xFE, rsp_cout=0. Then r0=0x07, r1=0x05 -> rsp_data=0x02, rsp_cout=1.
- Min and rotate: r0=0x80, r1=0x01, min -> 0x80, rsp_cout=0. Then rotate-right (1000) of r0=0x81 -> 0xC0.
- Illegal op: op=0101 -> rsp_err=1, rsp_data=0, alu_c stays 0, destination register unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid=1 -> rsp_* stable, cmd_ready=0 throughout. The next command is accepted only after the handshake.
- Reset: assert rst_n=0 during ISSUE of an add into r2 (previously 0x33) -> r2=0, rsp_valid never asserts, cmd_ready=1 after reset releases. Additionally, with ALU_SEQ_IMM_EN: add r0=0x10 with imm 0x22 -> 0x32.
